// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI transmit master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

    // Transmit sequencer states
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAIT,
        HOLD,
        GAP
    } spi_state_e;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Width of a counter that indexes all 2*data_w SCLK toggles of one word
    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Tick generator: one-cycle tick every CLK_DIV clk cycles, counted from restart.
// Latency: first tick CLK_DIV cycles after restart is released.
// Backpressure: none; restart_i holds the count at zero.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = !restart_i && (cnt_q == CNT_LAST);

    // Free-running modulo-CLK_DIV count, forced to zero while restart is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart_i || (cnt_q == CNT_LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_tx_master.sv
// SPI transmit master: serialises words onto MOSI with SCLK and CS_n, multi-word frames.
// Latency: cs_n falls 1 cycle after accept; cs_n low CLK_DIV*(2*DATA_W+2) cycles per single word.
// Backpressure: tx_ready low while the one-entry holding buffer is occupied.
module spi_tx_master
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 2,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int LSB_FIRST = 0,
    parameter int CS_GAP    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [1:0] MODE = {1'(CPOL), 1'(CPHA)};
    localparam bit IDLE_HI       = (MODE == SPI_MODE2) || (MODE == SPI_MODE3);
    localparam bit SHIFT_ON_LEAD = (MODE == SPI_MODE1) || (MODE == SPI_MODE3);

    localparam int BCW = bit_cnt_w(DATA_W);
    localparam logic [BCW-1:0] EDGE_LAST = BCW'(2 * DATA_W - 1);
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

    spi_state_e        state_q;
    logic              hold_vld_q;
    logic [DATA_W-1:0] hold_dat_q;
    logic              hold_last_q;
    logic [DATA_W-1:0] sh_q;
    logic              last_q;
    logic [BCW-1:0]    edge_q;
    logic [GW-1:0]     gap_q;
    logic              sclk_q;
    logic              mosi_q;
    logic              cs_n_q;
    logic              done_q;

    logic              tick;
    logic              div_restart;
    logic              take;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
    endfunction

    // The divider only times SETUP/SHIFT/HOLD; holding it in the other states
    // means every timed state starts with a fresh count. Timed states leave on
    // a tick, where the count wraps to zero by itself.
    assign div_restart = (state_q == IDLE) || (state_q == WAIT) || (state_q == GAP);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (div_restart),
        .tick_o    (tick)
    );

    assign tx_ready   = !hold_vld_q;
    assign busy       = (state_q != IDLE) || hold_vld_q;
    assign sclk       = sclk_q;
    assign mosi       = mosi_q;
    assign cs_n       = cs_n_q;
    assign frame_done = done_q;

    // Shifter takes the buffered word: frame start, resume after WAIT,
    // gapless word chaining, or a new frame straight out of GAP
    always_comb begin
        take = 1'b0;
        case (state_q)
            IDLE:    take = hold_vld_q;
            SHIFT:   take = tick && (edge_q == EDGE_LAST) && !last_q && hold_vld_q;
            WAIT:    take = hold_vld_q;
            GAP:     take = (gap_q == GAP_LAST) && hold_vld_q;
            default: take = 1'b0;
        endcase
    end

    // Sequencer, shift register, SPI pin registers and holding buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_vld_q  <= 1'b0;
            hold_dat_q  <= '0;
            hold_last_q <= 1'b0;
            sh_q        <= '0;
            last_q      <= 1'b0;
            edge_q      <= '0;
            gap_q       <= '0;
            sclk_q      <= IDLE_HI;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hold_vld_q) begin
                        cs_n_q  <= 1'b0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) state_q <= SHIFT;
                end
                SHIFT: begin
                    if (tick) begin
                        sclk_q <= ~sclk_q;
                        if (edge_q == EDGE_LAST) begin
                            edge_q <= '0;
                            if (last_q)           state_q <= HOLD;
                            else if (!hold_vld_q) state_q <= WAIT;
                        end else begin
                            edge_q <= edge_q + 1'b1;
                            // Even toggle index = leading edge, odd = trailing
                            if (SHIFT_ON_LEAD ? !edge_q[0] : edge_q[0]) begin
                                mosi_q <= first_bit(sh_q);
                                sh_q   <= advance(sh_q);
                            end
                        end
                    end
                end
                WAIT: begin
                    if (hold_vld_q) state_q <= SETUP;
                end
                HOLD: begin
                    if (tick) begin
                        cs_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        gap_q   <= '0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        if (hold_vld_q) begin
                            cs_n_q  <= 1'b0;
                            state_q <= SETUP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Leading-edge sampling modes need the first bit on MOSI before SCLK moves
            if (take) begin
                hold_vld_q <= 1'b0;
                last_q     <= hold_last_q;
                if (SHIFT_ON_LEAD) begin
                    sh_q <= hold_dat_q;
                end else begin
                    mosi_q <= first_bit(hold_dat_q);
                    sh_q   <= advance(hold_dat_q);
                end
            end

            // Only accepted while empty, so never collides with a take
            if (tx_valid && !hold_vld_q) begin
                hold_vld_q  <= 1'b1;
                hold_dat_q  <= tx_data;
                hold_last_q <= tx_last;
            end
        end
    end

endmodule

// File: tb/tb_spi_tx_master.sv
// Directed self-checking bench for spi_tx_master (mode 0 MSB-first and mode 3 LSB-first instances).
// Latency: n/a.
// Backpressure: words are offered until tx_ready is seen at a falling clock edge.
module tb_spi_tx_master;

    logic       clk = 1'b0;
    logic       rst0_n, rst3_n;

    logic [7:0] d0, d3;
    logic       l0, l3, v0, v3;
    logic       ready0, sclk0, mosi0, cs0, busy0, fd0;
    logic       ready3, sclk3, mosi3, cs3, busy3, fd3;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // dut0 observation state
    logic bitq[$];
    int   riseq[$];
    logic sclk0_prev = 1'b0;
    logic cs0_prev = 1'b1;
    int   cs_low_tot = 0;
    int   fd_tot = 0;
    int   fd_bad = 0;
    int   hi_run = 0;
    int   last_gap = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    spi_tx_master #(
        .DATA_W(8), .CLK_DIV(2), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .CS_GAP(3)
    ) dut0 (
        .clk(clk), .rst_n(rst0_n), .tx_data(d0), .tx_last(l0), .tx_valid(v0),
        .tx_ready(ready0), .sclk(sclk0), .mosi(mosi0), .cs_n(cs0),
        .busy(busy0), .frame_done(fd0)
    );

    spi_tx_master #(
        .DATA_W(8), .CLK_DIV(2), .CPOL(1), .CPHA(1), .LSB_FIRST(1), .CS_GAP(2)
    ) dut3 (
        .clk(clk), .rst_n(rst3_n), .tx_data(d3), .tx_last(l3), .tx_valid(v3),
        .tx_ready(ready3), .sclk(sclk3), .mosi(mosi3), .cs_n(cs3),
        .busy(busy3), .frame_done(fd3)
    );

    // Sample dut0 pins mid-cycle: rising SCLK bits, CS low time, CS high runs, frame_done
    always @(negedge clk) begin
        if (sclk0 && !sclk0_prev) begin
            bitq.push_back(mosi0);
            riseq.push_back(cyc);
        end
        sclk0_prev = sclk0;
        if (!cs0) cs_low_tot++;
        if (fd0) begin
            fd_tot++;
            if (!(cs0 && !cs0_prev)) fd_bad++;
        end
        if (cs0) begin
            hi_run++;
        end else begin
            if (hi_run != 0) last_gap = hi_run;
            hi_run = 0;
        end
        cs0_prev = cs0;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int bits_val(input int start, input int n);
        int v = 0;
        for (int i = 0; i < n; i++)
            if (start + i < bitq.size()) v = (v << 1) | int'(bitq[start + i]);
        return v;
    endfunction

    task automatic send0(input logic [7:0] d, input logic l, output int acc);
        int n = 0;
        @(negedge clk);
        d0 = d; l0 = l; v0 = 1'b1;
        while (!ready0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("send0_ready", 32'(n < 500), 1);
        @(posedge clk);
        #1;
        acc = cyc;
        v0 = 1'b0;
    endtask

    task automatic wait_idle0(input int budget);
        int n = 0;
        @(negedge clk);
        #1;
        while ((busy0 || !cs0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("idle0_wait", 32'(n < budget), 1);
    endtask

    task automatic wait_rises0(input int target, input int budget);
        int n = 0;
        while (bitq.size() < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rise0_wait", 32'(n < budget), 1);
    endtask

    // Send one single-word frame on dut3 and compare the rising-edge samples
    task automatic frame3(input logic [7:0] w, input logic [7:0] exp_samples);
        int n = 0;
        int nb = 0;
        logic [7:0] val = '0;
        logic prev;
        @(negedge clk);
        d3 = w; l3 = 1'b1; v3 = 1'b1;
        while (!ready3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        v3 = 1'b0;
        prev = sclk3;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            if (sclk3 && !prev) begin
                val = {val[6:0], mosi3};
                nb++;
            end
            prev = sclk3;
            n++;
        end while ((busy3 || !cs3) && n < 300);
        chk("m3_done", 32'(n < 300), 1);
        chk("m3_nbits", nb, 8);
        chk("m3_data", val, exp_samples);
        chk("m3_sclk_idle", sclk3, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b0, c0, f0, acc, acc2, bad, viol;
        rst0_n = 1'b0; rst3_n = 1'b0;
        d0 = '0; l0 = 1'b0; v0 = 1'b0;
        d3 = '0; l3 = 1'b0; v3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs", cs0, 1);
        chk("rst_sclk", sclk0, 0);
        chk("rst_mosi", mosi0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_fd", fd0, 0);
        chk("rst3_sclk", sclk3, 1);
        chk("rst3_cs", cs3, 1);
        rst0_n = 1'b1; rst3_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", ready0, 1);

        // Single word 0xA5, mode 0
        b0 = bitq.size(); c0 = cs_low_tot; f0 = fd_tot;
        send0(8'hA5, 1'b1, acc);
        chk("a_cs_pre", cs0, 1);
        @(posedge clk);
        #1;
        chk("a_cs_fall", cs0, 0);
        wait_idle0(200);
        chk("a_nbits", bitq.size() - b0, 8);
        chk("a_data", bits_val(b0, 8), 32'hA5);
        chk("a_cs_low", cs_low_tot - c0, 36);
        chk("a_fd", fd_tot - f0, 1);
        chk("a_sclk_idle", sclk0, 0);
        if (riseq.size() > b0) chk("a_first_rise", riseq[b0] - acc, 5);

        // Three-word frame, streamed
        b0 = bitq.size(); c0 = cs_low_tot; f0 = fd_tot;
        send0(8'h12, 1'b0, acc);
        send0(8'h34, 1'b0, acc);
        send0(8'h56, 1'b1, acc);
        wait_idle0(400);
        chk("b_nbits", bitq.size() - b0, 24);
        chk("b_data", bits_val(b0, 24), 32'h123456);
        chk("b_cs_low", cs_low_tot - c0, 100);
        chk("b_fd", fd_tot - f0, 1);
        bad = 0;
        for (int i = b0 + 1; i < riseq.size(); i++)
            if (riseq[i] - riseq[i - 1] != 4) bad++;
        chk("b_sclk_spacing", bad, 0);

        // Same frame with a 10-cycle stall before the second word
        b0 = bitq.size(); f0 = fd_tot;
        send0(8'h12, 1'b0, acc);
        wait_rises0(b0 + 8, 200);
        repeat (2) @(negedge clk);
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (cs0 || sclk0) viol++;
        end
        chk("c_wait_pins", viol, 0);
        send0(8'h34, 1'b0, acc2);
        send0(8'h56, 1'b1, acc);
        wait_idle0(400);
        chk("c_nbits", bitq.size() - b0, 24);
        chk("c_data", bits_val(b0, 24), 32'h123456);
        chk("c_fd", fd_tot - f0, 1);
        if (riseq.size() > b0 + 8) chk("c_setup", riseq[b0 + 8] - acc2, 5);

        // Two single-word frames back to back, CS_GAP = 3
        b0 = bitq.size(); f0 = fd_tot;
        send0(8'h81, 1'b1, acc);
        send0(8'h7E, 1'b1, acc);
        chk("d_ready_full", ready0, 0);
        wait_idle0(400);
        chk("d_nbits", bitq.size() - b0, 16);
        chk("d_data", bits_val(b0, 16), 32'h817E);
        chk("d_fd", fd_tot - f0, 2);
        chk("d_gap_min", 32'(last_gap >= 3), 1);

        // Reset during the 5th bit with a second word buffered
        b0 = bitq.size();
        send0(8'hF8, 1'b0, acc);
        send0(8'h00, 1'b0, acc);
        wait_rises0(b0 + 5, 200);
        chk("e_mosi_pre", mosi0, 1);
        rst0_n = 1'b0;
        #1;
        chk("e_cs", cs0, 1);
        chk("e_sclk", sclk0, 0);
        chk("e_mosi", mosi0, 0);
        chk("e_ready", ready0, 1);
        chk("e_busy", busy0, 0);
        @(negedge clk);
        rst0_n = 1'b1;
        b0 = bitq.size(); c0 = cs_low_tot; f0 = fd_tot;
        send0(8'hFF, 1'b1, acc);
        wait_idle0(200);
        chk("e_nbits", bitq.size() - b0, 8);
        chk("e_data", bits_val(b0, 8), 32'hFF);
        chk("e_cs_low", cs_low_tot - c0, 36);
        chk("e_fd", fd_tot - f0, 1);
        chk("fd_align", fd_bad, 0);

        // Mode 3, LSB first: samples listed first-sampled in the MSB position
        chk("m3_idle", sclk3, 1);
        frame3(8'h3C, 8'h3C);
        frame3(8'h01, 8'h80);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
